// File: rtl/stream_pkg.sv
// stream_pkg: shared definitions for the stream multiplexer family.
//   MODE_FIXED / MODE_RR : encoding of the mode_rr input
//   wrap_inc(idx, n)     : idx + 1 modulo n, used for round-robin scans
package stream_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Increment an index with wrap-around to 0 at n.
    function automatic int wrap_inc(input int idx, input int n);
        int nxt;
        nxt = idx + 32'sd1;
        if (nxt >= n) begin
            nxt = 32'sd0;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   req [N-1:0]  : request vector
//   ptr [SW-1:0] : index of the last granted requester; the scan starts one above it
//   gnt [N-1:0]  : one-hot grant, or all zero when nobody requests
module rr_arbiter
    import stream_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [SW-1:0] idx_s;
    logic          found_s;

    // Scan N positions starting at ptr+1 (wrapping) and grant the first requester.
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        idx_s   = SW'(wrap_inc(int'(ptr), N));
        for (int k = 0; k < N; k++) begin
            if (!found_s && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
            idx_s = SW'(wrap_inc(int'(idx_s), N));
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel valid/ready stream multiplexer with a registered output slot.
//   mode_rr   : 0 = channel chosen by sel, 1 = round-robin among valid channels
//   sel       : channel index for fixed mode (values >= N grant nothing)
//   in_valid / in_data / in_ready : per-channel input streams, channel i at in_data[i*W +: W]
//   out_valid / out_data / out_ch / out_ready : output stream plus source channel index
// One word per cycle is sustained because the slot reloads while it is being emptied.
module rr_stream_mux
    import stream_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode_rr,
    input  logic [SW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    input  logic           out_ready
);

    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q,  out_data_d;
    logic [SW-1:0]  out_ch_q,    out_ch_d;
    logic [SW-1:0]  rr_ptr_q,    rr_ptr_d;

    logic           load_en_s;
    logic [N-1:0]   gnt_rr_s;
    logic [N-1:0]   gnt_fixed_s;
    logic [N-1:0]   grant_s;
    logic [N-1:0]   in_ready_s;
    logic           accept_s;
    logic [SW-1:0]  win_idx_s;
    logic [W-1:0]   win_data_s;

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .req (in_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt_rr_s)
    );

    // Fixed-mode grant: only the selected channel, and only if it is valid.
    always_comb begin
        gnt_fixed_s = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SW'(i)) begin
                gnt_fixed_s[i] = in_valid[i];
            end else begin
                gnt_fixed_s[i] = 1'b0;
            end
        end
    end

    // Mode mux, accept strobes, and encoding of the winning channel.
    always_comb begin
        load_en_s = !out_valid_q || out_ready;
        if (mode_rr == MODE_RR) begin
            grant_s = gnt_rr_s;
        end else begin
            grant_s = gnt_fixed_s;
        end
        in_ready_s = grant_s & {N{load_en_s}};
        accept_s   = |(in_ready_s & in_valid);
        win_idx_s  = '0;
        win_data_s = '0;
        for (int i = 0; i < N; i++) begin
            if (in_ready_s[i]) begin
                win_idx_s  = SW'(i);
                win_data_s = in_data[i*W +: W];
            end else begin
                win_idx_s  = win_idx_s;
            end
        end
    end

    // Next-state for the output slot and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = win_data_s;
            out_ch_d    = win_idx_s;
            if (mode_rr == MODE_RR) begin
                rr_ptr_d = win_idx_s;
            end else begin
                rr_ptr_d = rr_ptr_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; pointer resets to N-1 so channel 0 wins the first scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= SW'(N - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-channel, W-bit multiplexer with valid/ready handshake on every input and on the single output.
- Generalises the 4:1 select mux. Adds a registered output stage and a runtime choice between two selection modes:
  - fixed select: `sel` picks the channel;
  - round-robin arbitration: fair selection among requesting channels.
- Sits between several producer streams and one shared consumer, e.g. a common UART/LED/display sink.

Parameters:
- N, 4, number of input channels (2..16)
- W, 8, data width per channel
- SW, $clog2(N), width of sel and out_ch

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mode_rr  in  1  0 = fixed select via sel, 1 = round-robin
- sel  in  SW  channel index used when mode_rr=0
- in_valid  in  N  per-channel data valid
- in_data  in  N*W  channel i occupies bits [i*W +: W]
- in_ready  out  N  per-channel accept strobe
- out_valid  out  1  output register holds a word
- out_data  out  W  registered selected word
- out_ch  out  SW  index of the channel that supplied out_data
- out_ready  in  1  consumer accepts out_data

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low, fully asynchronous assert; all flops clear immediately while it is low.
- Reset values:
  - out_valid=0, out_data=0, out_ch=0
  - rr_ptr=N-1, so channel 0 has first priority after reset
  - in_ready=0 (combinational, follows from the grant logic)
- load_en = !out_valid | out_ready. The output slot is free, or is being emptied this cycle.
- Grant is combinational, one-hot or zero:
  - mode_rr=0: grant[sel]=in_valid[sel]. If sel>=N, no grant.
  - mode_rr=1: the first i with in_valid[i]=1, scanning from (rr_ptr+1) mod N upward with wrap-around.
- in_ready[i] = load_en & grant[i]. At most one in_ready is high per cycle.
- Transfer in: when in_valid[i] & in_ready[i] at a rising edge:
  - out_data <= in_data[i], out_ch <= i, out_valid <= 1;
  - rr_ptr <= i (round-robin mode only).
- Transfer out: when out_valid & out_ready and no new grant, out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous out-accept and new grant: the register reloads in the same cycle. out_valid stays 1, giving full throughput of 1 word/cycle.
- Stall: while out_valid & !out_ready, out_data and out_ch are held stable and all in_ready=0.
- Latency: 1 cycle from input acceptance to out_valid.
- rr_ptr changes only on an accepted input. It is unchanged in fixed mode and unchanged when no input is accepted.
- Switching mode_rr or sel takes effect on the next grant evaluation and never disturbs a word already held in the output register.
- No requests: in_ready=0, and the output drains normally.
- Pointer wrap: if rr_ptr=N-1, the scan starts at channel 0.

Decomposition:
- Shared package `stream_pkg`:
  - localparam for the mode encoding (MODE_FIXED=0, MODE_RR=1);
  - helper function `wrap_inc(idx, N)`.
- One natural sub-module: `rr_arbiter`.
  - Inputs: req[N], ptr.
  - Output: one-hot gnt.
  - Purely combinational, reusable by other shared-sink blocks.
- The top level owns the output register, rr_ptr and the mode mux.

Test Plan (N=4, W=8):
- Reset: hold rst_n=0 mid-transfer with out_valid=1 -> out_valid, out_data and out_ch drop to 0 immediately (asynchronous). First RR grant after release goes to ch0.
- Fixed mode: mode_rr=0, sel=2, in_valid=4'b1111, data ch0..3=0x10,0x20,0x30,0x40, out_ready=1 -> every cycle out_data=0x30, out_ch=2, in_ready=4'b0100. With sel=2 and in_valid[2]=0 -> out_valid=0 after one cycle.
- Round-robin fairness: mode_rr=1, all four channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles, one word per cycle.
- Round-robin skip and wrap: in_valid=4'b1001 -> out_ch alternates 0,3,0,3. rr_ptr=3 with in_valid=4'b0100 -> out_ch=2.
- Backpressure: out_ready=0 for 5 cycles after a load of 0x20 from ch1 -> out_data=0x20 and out_ch=1 stay stable, in_ready=0. On out_ready=1, the next channel (ch2) is loaded in the same cycle and out_valid stays high.
- Mode switch while stalled: word from ch3 held, then mode_rr toggled 1->0 with sel=0 -> held word unchanged. After out_ready, the next word comes from ch0.
